maq_contador_bcd: RTL and testbench

//  Generic two-digit BCD modulo-N counter stage for the clock chain; one instance per field
//  (seconds MOD 60, minutes MOD 60, hours MOD 24 / MOD 12).

---
 rtl/maq_contador_bcd.sv | 178 +++++++++++++++++
 tb/tb_maq_contador_bcd.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/maq_contador_bcd.sv
// ---------------------------------------------------------------------------
// maq_contador_bcd
//
// Two-digit BCD modulo-N counter stage for the clock chain. One instance per
// time field (seconds MOD 60, minutes MOD 60, hours MOD 24 or MOD 12).
//
// The stage counts up or down on qualified ticks. It emits a one-cycle carry
// pulse on the wrap from MODULO-1 to 00, and a one-cycle borrow pulse on the
// wrap from 00 to MODULO-1. These pulses feed the next stage.
//
// Optional feature (compile-time macro MAQC_CARGA_EN):
//   When the macro is defined, a parallel load port is active. Invalid load
//   values are rejected with a one-cycle erro_carga pulse.
//   When the macro is undefined, no load logic exists. The load inputs are
//   ignored and erro_carga is tied to 0.
//
// Parameters
//   MODULO  count range 0..MODULO-1 (legal 2..100)
//   MSD_W   tens-digit width; must hold (MODULO-1)/10
//
// Ports
//   maqc_clock       in   1      system clock
//   maqc_reset       in   1      synchronous active-high reset
//   maqc_enable      in   1      tick qualifier
//   maqc_incremento  in   1      count-up request
//   maqc_decremento  in   1      count-down request
//   maqc_carga       in   1      parallel load strobe
//   maqc_carga_lsd   in   4      BCD units value to load
//   maqc_carga_msd   in   MSD_W  BCD tens value to load
//   maqc_lsd         out  4      units digit (BCD)
//   maqc_msd         out  MSD_W  tens digit (BCD)
//   maqc_carry       out  1      pulse on up-wrap
//   maqc_borrow      out  1      pulse on down-wrap
//   maqc_erro_carga  out  1      pulse on rejected load
// ---------------------------------------------------------------------------
module maq_contador_bcd #(
    parameter int MODULO = 60,
    parameter int MSD_W  = 3
) (
    input  logic             maqc_clock,
    input  logic             maqc_reset,
    input  logic             maqc_enable,
    input  logic             maqc_incremento,
    input  logic             maqc_decremento,
    input  logic             maqc_carga,
    input  logic [3:0]       maqc_carga_lsd,
    input  logic [MSD_W-1:0] maqc_carga_msd,
    output logic [3:0]       maqc_lsd,
    output logic [MSD_W-1:0] maqc_msd,
    output logic             maqc_carry,
    output logic             maqc_borrow,
    output logic             maqc_erro_carga
);

    // Digits of the terminal value MODULO-1.
    // The down-wrap lands on this value, and the up-wrap leaves from it.
    localparam logic [3:0]       LSD_MAX = 4'((MODULO - 1) % 10);
    localparam logic [MSD_W-1:0] MSD_MAX = MSD_W'((MODULO - 1) / 10);

    logic             step_up;
    logic             step_dn;
    logic             at_max;
    logic             at_zero;
    logic [3:0]       cont_lsd;
    logic [MSD_W-1:0] cont_msd;
    logic             cont_carry;
    logic             cont_borrow;

    // Conflicting up and down requests cancel each other out.
    assign step_up = maqc_enable & maqc_incremento & ~maqc_decremento;
    assign step_dn = maqc_enable & maqc_decremento & ~maqc_incremento;

    assign at_max  = (maqc_lsd == LSD_MAX) && (maqc_msd == MSD_MAX);
    assign at_zero = (maqc_lsd == 4'd0) && (maqc_msd == '0);

    // Next value from counting alone.
    // The wrap cases are tested first, so an up-step at MODULO-1 goes to 00
    // even when the units digit is not 9 (e.g. 23 -> 00 for MOD 24).
    // The carry and borrow pulses default to 0, so they only exist on the
    // wrap edge itself.
    always_comb begin
        cont_lsd    = maqc_lsd;
        cont_msd    = maqc_msd;
        cont_carry  = 1'b0;
        cont_borrow = 1'b0;
        if (step_up) begin
            if (at_max) begin
                cont_lsd   = 4'd0;
                cont_msd   = '0;
                cont_carry = 1'b1;
            end else if (maqc_lsd == 4'd9) begin
                cont_lsd = 4'd0;
                cont_msd = maqc_msd + MSD_W'(1);
            end else begin
                cont_lsd = maqc_lsd + 4'd1;
            end
        end else if (step_dn) begin
            if (at_zero) begin
                cont_lsd    = LSD_MAX;
                cont_msd    = MSD_MAX;
                cont_borrow = 1'b1;
            end else if (maqc_lsd == 4'd0) begin
                cont_lsd = 4'd9;
                cont_msd = maqc_msd - MSD_W'(1);
            end else begin
                cont_lsd = maqc_lsd - 4'd1;
            end
        end
    end

`ifdef MAQC_CARGA_EN
    // The load value is checked as a whole number.
    // The widest case is 15*10 + 15 = 165, which fits in 8 bits.
    localparam logic [7:0] MODULO_W = 8'(MODULO);

    logic [7:0] carga_valor;
    logic       carga_ok;

    assign carga_valor = 8'(maqc_carga_msd) * 8'd10 + 8'(maqc_carga_lsd);
    assign carga_ok    = (maqc_carga_lsd <= 4'd9) && (carga_valor < MODULO_W);

    // The digit register gives the load priority over counting.
    // A tick that coincides with a load is dropped.
    // A rejected load keeps the current digits, and still suppresses the tick.
    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            maqc_lsd    <= 4'd0;
            maqc_msd    <= '0;
            maqc_carry  <= 1'b0;
            maqc_borrow <= 1'b0;
        end else if (maqc_carga) begin
            if (carga_ok) begin
                maqc_lsd <= maqc_carga_lsd;
                maqc_msd <= maqc_carga_msd;
            end
            maqc_carry  <= 1'b0;
            maqc_borrow <= 1'b0;
        end else begin
            maqc_lsd    <= cont_lsd;
            maqc_msd    <= cont_msd;
            maqc_carry  <= cont_carry;
            maqc_borrow <= cont_borrow;
        end
    end

    // Load-error pulse: set for exactly the edge that rejects a load.
    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            maqc_erro_carga <= 1'b0;
        end else begin
            maqc_erro_carga <= maqc_carga & ~carga_ok;
        end
    end
`else
    // No load path in this build.
    // The load inputs are only folded into a sink so that they have a reader.
    logic unused_carga;
    assign unused_carga = ^{maqc_carga, maqc_carga_lsd, maqc_carga_msd};

    // Digit and pulse registers, updated from counting alone.
    always_ff @(posedge maqc_clock) begin
        if (maqc_reset) begin
            maqc_lsd    <= 4'd0;
            maqc_msd    <= '0;
            maqc_carry  <= 1'b0;
            maqc_borrow <= 1'b0;
        end else begin
            maqc_lsd    <= cont_lsd;
            maqc_msd    <= cont_msd;
            maqc_carry  <= cont_carry;
            maqc_borrow <= cont_borrow;
        end
    end

    assign maqc_erro_carga = 1'b0;
`endif

endmodule

// File: tb/tb_maq_contador_bcd.sv
// ---------------------------------------------------------------------------
// tb_maq_contador_bcd
//
// Directed bench for maq_contador_bcd with two instances:
//   dutA  MODULO=60, MSD_W=3
//   dutB  MODULO=24, MSD_W=2
//
// A vector table drives dutA through counting, wraps, idle cycles and reset.
// Hand-written sequences cover the longer multi-cycle cases and the load port.
// Define MAQC_CARGA_EN for both the RTL and the bench to exercise loading.
// ---------------------------------------------------------------------------
module tb_maq_contador_bcd;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // dutA signals
    logic       resetA = 1'b0, enableA = 1'b0, incA = 1'b0, decA = 1'b0, cargaA = 1'b0;
    logic [3:0] cargaLsdA = 4'd0;
    logic [2:0] cargaMsdA = 3'd0;
    logic [3:0] lsdA;
    logic [2:0] msdA;
    logic       carryA, borrowA, erroA;

    // dutB signals
    logic       resetB = 1'b0, enableB = 1'b0, incB = 1'b0, decB = 1'b0, cargaB = 1'b0;
    logic [3:0] cargaLsdB = 4'd0;
    logic [1:0] cargaMsdB = 2'd0;
    logic [3:0] lsdB;
    logic [1:0] msdB;
    logic       carryB, borrowB, erroB;

    int compared   = 0;
    int mismatched = 0;

    maq_contador_bcd #(.MODULO(60), .MSD_W(3)) dutA (
        .maqc_clock(clock), .maqc_reset(resetA), .maqc_enable(enableA),
        .maqc_incremento(incA), .maqc_decremento(decA), .maqc_carga(cargaA),
        .maqc_carga_lsd(cargaLsdA), .maqc_carga_msd(cargaMsdA),
        .maqc_lsd(lsdA), .maqc_msd(msdA), .maqc_carry(carryA),
        .maqc_borrow(borrowA), .maqc_erro_carga(erroA)
    );

    maq_contador_bcd #(.MODULO(24), .MSD_W(2)) dutB (
        .maqc_clock(clock), .maqc_reset(resetB), .maqc_enable(enableB),
        .maqc_incremento(incB), .maqc_decremento(decB), .maqc_carga(cargaB),
        .maqc_carga_lsd(cargaLsdB), .maqc_carga_msd(cargaMsdB),
        .maqc_lsd(lsdB), .maqc_msd(msdB), .maqc_carry(carryB),
        .maqc_borrow(borrowB), .maqc_erro_carga(erroB)
    );

    typedef struct {
        int rst; int en; int inc; int dec;
        int lsd; int msd; int carry; int borrow;
    } vec_t;

    vec_t vecs[30];

    // Single comparison; every check in the bench goes through here.
    task automatic checkOutput(input string name, input int got, input int expected);
        compared++;
        if (got != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, expected);
        end
    endtask

    // Checks all outputs of dutA.
    task automatic checkA(input string tag, input int eLsd, input int eMsd,
                          input int eCarry, input int eBorrow, input int eErro);
        checkOutput({tag, ".lsd"},    int'(lsdA),    eLsd);
        checkOutput({tag, ".msd"},    int'(msdA),    eMsd);
        checkOutput({tag, ".carry"},  int'(carryA),  eCarry);
        checkOutput({tag, ".borrow"}, int'(borrowA), eBorrow);
        checkOutput({tag, ".erro"},   int'(erroA),   eErro);
    endtask

    // Checks all outputs of dutB.
    task automatic checkB(input string tag, input int eLsd, input int eMsd,
                          input int eCarry, input int eBorrow, input int eErro);
        checkOutput({tag, ".lsd"},    int'(lsdB),    eLsd);
        checkOutput({tag, ".msd"},    int'(msdB),    eMsd);
        checkOutput({tag, ".carry"},  int'(carryB),  eCarry);
        checkOutput({tag, ".borrow"}, int'(borrowB), eBorrow);
        checkOutput({tag, ".erro"},   int'(erroB),   eErro);
    endtask

    // Drives dutA for one edge, then waits until just after that edge.
    task automatic applyStimulus(input int rst, input int en, input int inc, input int dec);
        resetA  = (rst != 0);
        enableA = (en  != 0);
        incA    = (inc != 0);
        decA    = (dec != 0);
        @(posedge clock);
        #1;
    endtask

    // Drives dutB for one edge, including the load port.
    task automatic applyStimulusB(input int rst, input int en, input int inc, input int dec,
                                  input int ld, input int cl, input int cm);
        resetB    = (rst != 0);
        enableB   = (en  != 0);
        incB      = (inc != 0);
        decB      = (dec != 0);
        cargaB    = (ld  != 0);
        cargaLsdB = 4'(cl);
        cargaMsdB = 2'(cm);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs = '{
            '{1,0,0,0, 0,0,0,0},   // reset
            '{0,0,0,0, 0,0,0,0},   // idle
            '{0,1,1,0, 1,0,0,0},   // up
            '{0,1,0,0, 1,0,0,0},   // enable without request
            '{0,1,1,0, 2,0,0,0},
            '{0,1,0,1, 1,0,0,0},   // down
            '{0,1,0,1, 0,0,0,0},
            '{0,1,0,1, 9,5,0,1},   // 00 -> 59 borrow
            '{0,0,0,0, 9,5,0,0},   // borrow gone
            '{0,1,0,1, 8,5,0,0},   // 58
            '{0,1,1,0, 9,5,0,0},   // 59
            '{0,1,1,0, 0,0,1,0},   // 59 -> 00 carry
            '{0,0,1,0, 0,0,0,0},   // inc held, enable low x5
            '{0,0,1,0, 0,0,0,0},
            '{0,0,1,0, 0,0,0,0},
            '{0,0,1,0, 0,0,0,0},
            '{0,0,1,0, 0,0,0,0},
            '{0,1,1,0, 1,0,0,0},
            '{0,1,0,1, 0,0,0,0},
            '{0,1,0,1, 9,5,0,1},
            '{0,1,0,1, 8,5,0,0},   // back-to-back: borrow drops
            '{0,1,1,0, 9,5,0,0},
            '{0,1,1,0, 0,0,1,0},
            '{0,1,1,0, 1,0,0,0},   // back-to-back: carry drops
            '{0,1,1,1, 1,0,0,0},   // both requests cancel
            '{0,0,0,1, 1,0,0,0},   // dec without enable
            '{0,1,0,1, 0,0,0,0},
            '{0,1,0,1, 9,5,0,1},   // at 59
            '{1,1,1,0, 0,0,0,0},   // reset wins over up-tick at 59
            '{0,0,0,0, 0,0,0,0}
        };

        // Table-driven run on dutA.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].inc, vecs[i].dec);
            checkA($sformatf("vec[%0d]", i), vecs[i].lsd, vecs[i].msd,
                   vecs[i].carry, vecs[i].borrow, 0);
        end

        // Count up to 37, checking every step including 09 -> 10 etc.
        for (int i = 1; i <= 37; i++) begin
            applyStimulus(0, 1, 1, 0);
            checkA($sformatf("up[%0d]", i), i % 10, i / 10, 0, 0, 0);
        end

        // Reset held for 3 cycles while ticks arrive: the ticks are lost.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0);
            checkA($sformatf("rst37[%0d]", i), 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkA($sformatf("post_rst[%0d]", i), 0, 0, 0, 0, 0);
        end

        // Go to 45, then apply both requests together.
        for (int i = 0; i < 45; i++) applyStimulus(0, 1, 1, 0);
        checkA("at45", 5, 4, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        checkA("both45", 5, 4, 0, 0, 0);

        // Count down from 45 to 09, crossing several tens boundaries.
        for (int i = 1; i <= 36; i++) begin
            applyStimulus(0, 1, 0, 1);
            checkA($sformatf("dn[%0d]", i), (45 - i) % 10, (45 - i) / 10, 0, 0, 0);
        end

`ifndef MAQC_CARGA_EN
        // Without the load feature, the load strobe must have no effect.
        cargaA    = 1'b1;
        cargaLsdA = 4'd1;
        cargaMsdA = 3'd1;
        applyStimulus(0, 0, 0, 0);
        checkA("carga_ignored", 9, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0);
        checkA("carga_ignored_tick", 0, 1, 0, 0, 0);
        cargaA = 1'b0;
`endif

        // Modulo-24 sequences on dutB.
        applyStimulusB(1, 0, 0, 0, 0, 0, 0);
        checkB("b_rst", 0, 0, 0, 0, 0);
        applyStimulusB(0, 1, 0, 1, 0, 0, 0);
        checkB("b_00to23", 3, 2, 0, 1, 0);
        applyStimulusB(0, 1, 0, 1, 0, 0, 0);
        checkB("b_22", 2, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulusB(0, 1, 0, 1, 0, 0, 0);
        checkB("b_19", 9, 1, 0, 0, 0);
        applyStimulusB(0, 1, 1, 0, 0, 0, 0);
        checkB("b_20", 0, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulusB(0, 1, 1, 0, 0, 0, 0);
        checkB("b_23", 3, 2, 0, 0, 0);
        applyStimulusB(0, 1, 1, 0, 0, 0, 0);
        checkB("b_23to00", 0, 0, 1, 0, 0);
        applyStimulusB(0, 0, 0, 0, 0, 0, 0);
        checkB("b_idle", 0, 0, 0, 0, 0);

`ifdef MAQC_CARGA_EN
        // Load sequences (MOD 24).
        applyStimulusB(0, 0, 0, 0, 1, 5, 1);
        checkB("ld_15", 5, 1, 0, 0, 0);
        applyStimulusB(0, 0, 0, 0, 1, 7, 2);
        checkB("ld_27_rej", 5, 1, 0, 0, 1);
        applyStimulusB(0, 0, 0, 0, 0, 0, 0);
        checkB("ld_err_gone", 5, 1, 0, 0, 0);
        applyStimulusB(0, 0, 0, 0, 1, 12, 0);
        checkB("ld_0C_rej", 5, 1, 0, 0, 1);
        applyStimulusB(0, 1, 1, 0, 1, 3, 2);
        checkB("ld_23_tick", 3, 2, 0, 0, 0);
        applyStimulusB(0, 1, 1, 0, 1, 4, 0);
        checkB("ld_04_over_wrap", 4, 0, 0, 0, 0);
        applyStimulusB(0, 1, 1, 0, 0, 0, 0);
        checkB("ld_then_up", 5, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
